traffic_light_monitor: RTL and testbench

Passive protocol checker on the light outputs of the two-street traffic light controller. It samples street A and street B light vectors every cycle and tracks each street's phase with its own state machine. It reports encoding, conflict, sequence and yellow-timing violations as sticky flags plus a saturating violation counter. It sits beside the controller in simulation and on the board, and never drives the controller.

---
 rtl/traffic_light_monitor.sv | 157 +++++++++++++++
 tb/tb_traffic_light_monitor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for the two-street traffic light outputs: encoding, conflict,
// sequence and yellow-timing violations. Optional macro TLM_SENSOR_CHECK_EN adds sensor checks.
module traffic_light_monitor #(
   parameter int unsigned YELLOW_CYCLES = 5,
   parameter int unsigned ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           la,
   input  logic [2:0]           lb,
   input  logic                 clear,
`ifdef TLM_SENSOR_CHECK_EN
   input  logic                 sa,
   input  logic                 sb,
   output logic                 err_sensor,
`endif
   output logic                 err_illegal,
   output logic                 err_conflict,
   output logic                 err_sequence,
   output logic                 err_timing,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [15:0]          cycles_done
);

   localparam int unsigned YCW = $clog2(YELLOW_CYCLES + 2);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {S_INIT, S_GREEN, S_YELLOW, S_RED, S_BAD} state_t;

   function automatic logic is_legal(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   function automatic state_t decode(input logic [2:0] v);
      case (v)
         3'b001:  return S_GREEN;
         3'b010:  return S_YELLOW;
         default: return S_RED;
      endcase
   endfunction

   state_t         r_st [2];
   state_t         w_st_nxt [2];
   logic [YCW-1:0] r_ycnt [2];
   logic [YCW-1:0] w_ycnt_nxt [2];
   logic [2:0]     w_lt [2];
   logic [1:0]     w_ill, w_seq, w_tim, w_sens;
   logic           w_conf, w_viol, w_a_viol, w_a_rg, w_a_yr;
   logic           r_round;

   assign w_lt[0] = la;
   assign w_lt[1] = lb;

   // Per-street phase tracking and yellow length measurement
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         w_st_nxt[s]   = r_st[s];
         w_ycnt_nxt[s] = r_ycnt[s];
         w_ill[s]      = 1'b0;
         w_seq[s]      = 1'b0;
         w_tim[s]      = 1'b0;
         if (!is_legal(w_lt[s])) begin
            w_ill[s]    = 1'b1;
            w_st_nxt[s] = S_BAD;
         end else begin
            w_st_nxt[s] = decode(w_lt[s]);
            if ((r_st[s] == S_GREEN || r_st[s] == S_YELLOW || r_st[s] == S_RED) &&
                (w_st_nxt[s] != r_st[s]) &&
                !((r_st[s] == S_GREEN  && w_st_nxt[s] == S_YELLOW) ||
                  (r_st[s] == S_YELLOW && w_st_nxt[s] == S_RED)    ||
                  (r_st[s] == S_RED    && w_st_nxt[s] == S_GREEN)))
               w_seq[s] = 1'b1;
         end
         if (w_st_nxt[s] == S_YELLOW) begin
            if (r_st[s] != S_YELLOW)
               w_ycnt_nxt[s] = YCW'(1);
            else if (r_ycnt[s] != YCW'(YELLOW_CYCLES + 1))
               w_ycnt_nxt[s] = r_ycnt[s] + YCW'(1);
            // Overrun flags once: the counter saturates one past the limit
            if (r_st[s] == S_YELLOW && r_ycnt[s] == YCW'(YELLOW_CYCLES))
               w_tim[s] = 1'b1;
         end else begin
            w_ycnt_nxt[s] = '0;
            if (r_st[s] == S_YELLOW && r_ycnt[s] < YCW'(YELLOW_CYCLES))
               w_tim[s] = 1'b1;
         end
      end
   end

`ifdef TLM_SENSOR_CHECK_EN
   logic [1:0] r_sprev;
   always_comb begin
      w_sens = '0;
      for (int s = 0; s < 2; s++)
         w_sens[s] = (r_st[s] == S_GREEN) && (w_st_nxt[s] == S_YELLOW) && r_sprev[s];
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sprev    <= '0;
         err_sensor <= 1'b0;
      end else begin
         r_sprev    <= {sb, sa};
         err_sensor <= (err_sensor & ~clear) | (|w_sens);
      end
   end
`else
   assign w_sens = '0;
`endif

   assign w_conf   = (la != 3'b100) && (lb != 3'b100);
   assign w_a_viol = w_ill[0] | w_seq[0] | w_tim[0] | w_sens[0];
   assign w_viol   = (|w_ill) | (|w_seq) | (|w_tim) | (|w_sens) | w_conf;
   assign w_a_rg   = (r_st[0] == S_RED)    && (w_st_nxt[0] == S_GREEN);
   assign w_a_yr   = (r_st[0] == S_YELLOW) && (w_st_nxt[0] == S_RED);

   // State, sticky flags, counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < 2; s++) begin
            r_st[s]   <= S_INIT;
            r_ycnt[s] <= '0;
         end
         r_round      <= 1'b0;
         err_illegal  <= 1'b0;
         err_conflict <= 1'b0;
         err_sequence <= 1'b0;
         err_timing   <= 1'b0;
         err_count    <= '0;
         cycles_done  <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            r_st[s]   <= w_st_nxt[s];
            r_ycnt[s] <= w_ycnt_nxt[s];
         end
         err_illegal  <= (err_illegal  & ~clear) | (|w_ill);
         err_conflict <= (err_conflict & ~clear) | w_conf;
         err_sequence <= (err_sequence & ~clear) | (|w_seq);
         err_timing   <= (err_timing   & ~clear) | (|w_tim);
         if (w_viol) begin
            if (clear)
               err_count <= ERR_CNT_W'(1);
            else if (err_count != CNT_MAX)
               err_count <= err_count + ERR_CNT_W'(1);
         end else if (clear) begin
            err_count <= '0;
         end
         // A round counts only if green was entered from red and A stayed clean
         if (w_a_yr && r_round && !w_a_viol)
            cycles_done <= cycles_done + 16'd1;
         if (w_a_rg)
            r_round <= 1'b1;
         else if (w_a_viol || w_a_yr)
            r_round <= 1'b0;
      end
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor (default parameters).
module tb_traffic_light_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] la, lb;
   logic       clear;
   logic       err_illegal, err_conflict, err_sequence, err_timing;
   logic [7:0] err_count;
   logic [15:0] cycles_done;
`ifdef TLM_SENSOR_CHECK_EN
   logic sa, sb, err_sensor;
`endif

   int n_cmp = 0;
   int n_err = 0;

   traffic_light_monitor #(.YELLOW_CYCLES(5), .ERR_CNT_W(8)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .la           (la),
      .lb           (lb),
      .clear        (clear),
`ifdef TLM_SENSOR_CHECK_EN
      .sa           (sa),
      .sb           (sb),
      .err_sensor   (err_sensor),
`endif
      .err_illegal  (err_illegal),
      .err_conflict (err_conflict),
      .err_sequence (err_sequence),
      .err_timing   (err_timing),
      .err_count    (err_count),
      .cycles_done  (cycles_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] a, input logic [2:0] b, input int n);
      la = a;
      lb = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_flags(input string tag, input logic [3:0] exp_flags, input logic [7:0] exp_cnt);
      chk({tag, "_flags"}, {28'd0, err_illegal, err_conflict, err_sequence, err_timing}, {28'd0, exp_flags});
      chk({tag, "_count"}, {24'd0, err_count}, {24'd0, exp_cnt});
   endtask

   initial begin
      reset = 1'b0;
      la = 3'b100;
      lb = 3'b100;
      clear = 1'b0;
`ifdef TLM_SENSOR_CHECK_EN
      sa = 1'b0;
      sb = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk_flags("reset", 4'b0000, 8'd0);
      chk("reset_cycles", {16'd0, cycles_done}, 32'd0);
      reset = 1'b1;

      // Start-up sequence: A green x4, yellow x5, then A red / B green
      drive(3'b001, 3'b100, 4);
      drive(3'b010, 3'b100, 5);
      drive(3'b100, 3'b001, 1);
      chk_flags("startup", 4'b0000, 8'd0);
      chk("startup_cycles", {16'd0, cycles_done}, 32'd0);

      // B back to red legally, then a clean round on A
      drive(3'b100, 3'b010, 5);
      drive(3'b100, 3'b100, 1);
      drive(3'b001, 3'b100, 3);
      drive(3'b010, 3'b100, 5);
      drive(3'b100, 3'b100, 1);
      chk_flags("round", 4'b0000, 8'd0);
      chk("round_cycles", {16'd0, cycles_done}, 32'd1);

      // Short yellow (4 cycles)
      drive(3'b001, 3'b100, 1);
      drive(3'b010, 3'b100, 4);
      chk("short_pre", {31'd0, err_timing}, 32'd0);
      drive(3'b100, 3'b100, 1);
      chk_flags("short", 4'b0001, 8'd1);
      chk("short_cycles", {16'd0, cycles_done}, 32'd1);

      clear = 1'b1;
      drive(3'b100, 3'b100, 1);
      clear = 1'b0;
      chk_flags("clear1", 4'b0000, 8'd0);

      // Long yellow (7 cycles): flag on the 6th yellow sample, counted once
      drive(3'b001, 3'b100, 1);
      drive(3'b010, 3'b100, 5);
      chk("long_5", {31'd0, err_timing}, 32'd0);
      drive(3'b010, 3'b100, 1);
      chk_flags("long_6", 4'b0001, 8'd1);
      drive(3'b010, 3'b100, 1);
      drive(3'b100, 3'b100, 1);
      chk_flags("long_end", 4'b0001, 8'd1);
      chk("long_cycles", {16'd0, cycles_done}, 32'd1);

      // Conflict + sequence (A R->Y, B R->G) in one sample: one count
      clear = 1'b1;
      drive(3'b100, 3'b100, 1);
      clear = 1'b0;
      drive(3'b010, 3'b001, 1);
      chk_flags("conf_seq", 4'b0110, 8'd1);
      // Illegal code while A yellow for 1 cycle: illegal + timing + conflict
      drive(3'b011, 3'b001, 1);
      chk_flags("illegal", 4'b1111, 8'd2);

      // Saturation: violations every cycle
      drive(3'b011, 3'b001, 260);
      chk_flags("sat", 4'b1111, 8'd255);
      drive(3'b100, 3'b001, 1);
      chk_flags("resync", 4'b1111, 8'd255);

      // Clear in the same cycle as a new conflict (A R->G legal)
      clear = 1'b1;
      drive(3'b001, 3'b001, 1);
      clear = 1'b0;
      chk_flags("clr_conf", 4'b0100, 8'd1);

      // Reset mid-yellow on A
      drive(3'b010, 3'b001, 2);
      chk("pre_rst_cycles", {16'd0, cycles_done}, 32'd1);
      chk("pre_rst_count", {24'd0, err_count}, 32'd3);
      reset = 1'b0;
      #1;
      chk_flags("async_rst", 4'b0000, 8'd0);
      chk("async_rst_cycles", {16'd0, cycles_done}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // First sample after reset is yellow: no sequence check, 5 cycles is legal
      drive(3'b010, 3'b100, 5);
      drive(3'b100, 3'b100, 1);
      chk_flags("post_rst", 4'b0000, 8'd0);

`ifdef TLM_SENSOR_CHECK_EN
      sa = 1'b0;
      drive(3'b001, 3'b100, 2);
      drive(3'b010, 3'b100, 1);
      chk("sens_off", {31'd0, err_sensor}, 32'd0);
      drive(3'b010, 3'b100, 4);
      drive(3'b100, 3'b100, 1);
      sa = 1'b1;
      drive(3'b001, 3'b100, 2);
      sa = 1'b0;
      drive(3'b010, 3'b100, 1);
      chk("sens_on", {31'd0, err_sensor}, 32'd1);
      chk("sens_count", {24'd0, err_count}, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
